// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative MIPS DIV/DIVU unit.
// State encoding, ALU-control codes and the divide-by-zero quotient.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam logic [7:0] ALU_DIV  = 8'b0001_1010;
    localparam logic [7:0] ALU_DIVU = 8'b0001_1011;

    localparam int                   DIV_WIDTH  = 32;
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_unit_step.sv
// One restoring division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep or restore.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_unused_hi;

    assign w_shift = {i_rem, i_bit};
    assign w_diff  = {1'b0, w_shift} - {2'b00, i_divisor};
    assign o_qbit  = ~w_diff[WIDTH+1];
    // Partial remainder stays below the divisor, so a kept difference fits WIDTH bits.
    assign o_rem   = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_unused_hi = w_diff[WIDTH];

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU.
// Produces {HI=remainder, LO=quotient}; stalls F/D/E while iterating.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic               annul,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall
);

    div_state_e         r_state;
    div_state_e         w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dvs;
    logic               r_sign_q;
    logic               r_sign_r;
    logic [2*WIDTH-1:0] r_result;

    logic             w_go;
    logic             w_zero;
    logic             w_last;
    logic             w_s1;
    logic             w_s2;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_fq;
    logic [WIDTH-1:0] w_fr;
    logic             w_qbit;

    assign w_go   = start & ~annul;
    assign w_zero = (opdata2 == '0);
    assign w_last = (r_cnt == CNT_W'(WIDTH-1));
    assign w_s1   = signed_div & opdata1[WIDTH-1];
    assign w_s2   = signed_div & opdata2[WIDTH-1];
    assign w_mag1 = w_s1 ? -opdata1 : opdata1;
    assign w_mag2 = w_s2 ? -opdata2 : opdata2;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_quo[WIDTH-1]),
        .i_divisor (r_dvs),
        .o_rem     (w_rem),
        .o_qbit    (w_qbit)
    );

    // r_quo shifts the dividend out of its MSB while quotient bits enter the LSB.
    assign w_q  = {r_quo[WIDTH-2:0], w_qbit};
    assign w_fq = r_sign_q ? -w_q : w_q;
    assign w_fr = r_sign_r ? -w_rem : w_rem;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            DIV_IDLE: begin
                if (w_go)
                    w_next = w_zero ? DIV_DONE : DIV_BUSY;
            end
            DIV_BUSY: begin
                if (annul)
                    w_next = DIV_IDLE;
                else if (w_last)
                    w_next = DIV_DONE;
            end
            DIV_DONE: w_next = DIV_IDLE;
            default:  w_next = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= DIV_IDLE;
            r_cnt    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == DIV_IDLE && w_go) begin
                if (w_zero) begin
                    r_result <= {opdata1, WIDTH'(DIV_ZERO_Q)};
                end else begin
                    r_quo    <= w_mag1;
                    r_dvs    <= w_mag2;
                    r_rem    <= '0;
                    r_cnt    <= '0;
                    r_sign_q <= w_s1 ^ w_s2;
                    r_sign_r <= w_s1;
                end
            end else if (r_state == DIV_BUSY && !annul) begin
                r_rem <= w_rem;
                r_quo <= w_q;
                r_cnt <= r_cnt + 1'b1;
                if (w_last)
                    r_result <= {w_fr, w_fq};
            end
        end
    end

    assign result = r_result;
    assign ready  = (r_state == DIV_DONE) & ~annul;
    assign stall  = ((r_state == DIV_IDLE) & w_go) | (r_state == DIV_BUSY);

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
// Hand-computed quotient/remainder pairs, latency and stall checks.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic        annul;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic [63:0] result;
    logic        ready;
    logic        stall;

    int n_checks = 0;
    int n_errors = 0;

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .result     (result),
        .ready      (ready),
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Starts an operation in the next cycle (cycle 0) and waits for ready.
    // Returns at the negedge of the ready cycle with start still high.
    task automatic run_div(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input logic sgn,
                           input logic [63:0] exp, input int lat);
        int  cyc;
        bit  seen;
        @(posedge clk);
        #1;
        opdata1    = a;
        opdata2    = b;
        signed_div = sgn;
        start      = 1'b1;
        cyc        = 0;
        seen       = 0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            if (ready) begin
                seen = 1;
                check({tag, "_lat"}, 64'(cyc), 64'(lat));
                check({tag, "_res"}, result, exp);
                check({tag, "_stall_done"}, 64'(stall), 64'd0);
            end else if (cyc == 0 || cyc == lat - 1) begin
                check({tag, "_stall_busy"}, 64'(stall), 64'd1);
            end
            if (!seen) begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        if (!seen)
            check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        start = 1'b0;
        annul = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_cnt;
        rst        = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        annul      = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        #12;
        check("rst_result", result, 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_stall0", 64'(stall), 64'd0);
        start = 1'b1;
        #1;
        check("rst_stall_comb", 64'(stall), 64'd1);
        start = 1'b0;
        #10;
        rst = 1'b1;

        run_div("divu_100_7", 32'd100, 32'd7, 1'b0,
                {32'd2, 32'd14}, 33);
        go_idle();
        run_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1,
                {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        go_idle();
        run_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1,
                {32'h0000_0001, 32'hFFFF_FFFD}, 33);
        go_idle();
        run_div("div0_u", 32'h1234_5678, 32'd0, 1'b0,
                {32'h1234_5678, 32'hFFFF_FFFF}, 1);
        go_idle();
        run_div("div0_s", 32'hFFFF_FFFB, 32'd0, 1'b1,
                {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1);
        go_idle();

        // Annul mid-iteration: flush drops start together with annul.
        @(posedge clk);
        #1;
        opdata1    = 32'd100;
        opdata2    = 32'd7;
        signed_div = 1'b0;
        start      = 1'b1;
        rdy_cnt    = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (ready)
                rdy_cnt++;
        end
        annul = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("annul_stall_c10", 64'(stall), 64'd1);
        check("annul_ready_c10", 64'(ready), 64'd0);
        @(posedge clk);
        #1;
        annul = 1'b0;
        @(negedge clk);
        check("annul_idle_c11", 64'(stall), 64'd0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready)
                rdy_cnt++;
        end
        check("annul_no_ready", 64'(rdy_cnt), 64'd0);
        check("annul_result_kept", result, {32'hFFFF_FFFB, 32'hFFFF_FFFF});

        // Asynchronous reset mid-iteration.
        @(posedge clk);
        #1;
        opdata1 = 32'd100;
        opdata2 = 32'd7;
        start   = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b0;
        #1;
        check("arst_ready", 64'(ready), 64'd0);
        check("arst_result", result, 64'd0);
        start = 1'b0;
        #1;
        check("arst_stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
                {32'h0000_0000, 32'h8000_0000}, 33);
        go_idle();

        // Back-to-back: second start held right after the first DONE.
        run_div("b2b_first", 32'hFFFF_FFFF, 32'h10, 1'b0,
                {32'h0000_000F, 32'h0FFF_FFFF}, 33);
        run_div("b2b_second", 32'd9, 32'd3, 1'b0,
                {32'd0, 32'd3}, 33);
        go_idle();
        @(negedge clk);
        check("final_idle_stall", 64'(stall), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
